// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the miniLA datapath.
// Define CTRL_PERF_CNT_EN to build the cycle and retired-instruction counters.
module mc_ctrl_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  inst_type,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  A_sel,
  output logic [1:0]  B_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
);

  localparam logic [1:0] A_RD1   = 2'd0;
  localparam logic [1:0] A_SEXT1 = 2'd1;
  localparam logic [1:0] A_1R    = 2'd2;

  localparam logic [1:0] B_RD2  = 2'd0;
  localparam logic [1:0] B_SEXT = 2'd1;
  localparam logic [1:0] B_ZERO = 2'd2;
  localparam logic [1:0] B_PC   = 2'd3;

  localparam logic [2:0] ClsAluR    = 3'd0;
  localparam logic [2:0] ClsAluI    = 3'd1;
  localparam logic [2:0] ClsLu12i   = 3'd2;
  localparam logic [2:0] ClsLoad    = 3'd3;
  localparam logic [2:0] ClsStore   = 3'd4;
  localparam logic [2:0] ClsBranch  = 3'd5;
  localparam logic [2:0] ClsJal     = 3'd6;
  localparam logic [2:0] ClsIllegal = 3'd7;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] class_q, class_d;
  logic [1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic       dmem_req_q, dmem_we_q, rf_we_q, halted_q;
  logic [1:0] wb_sel_q, wb_sel_d;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      StIf:   if (run && imem_ack) state_d = StId;
      StId: begin
        class_d = inst_type;
        state_d = (inst_type == ClsIllegal) ? StHalt : StEx;
      end
      StEx: begin
        if (class_q == ClsLoad || class_q == ClsStore) state_d = StMem;
        else if (class_q == ClsBranch)                 state_d = StIf;
        else                                           state_d = StWb;
      end
      StMem:  if (dmem_ack) state_d = (class_q == ClsLoad) ? StWb : StIf;
      StWb:   state_d = StIf;
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Operand selects are loaded on entry to EX and held until the next EX.
  always_comb begin
    a_sel_d = a_sel_q;
    b_sel_d = b_sel_q;
    if (state_d == StEx) begin
      case (class_d)
        ClsAluR, ClsBranch: begin a_sel_d = A_RD1;   b_sel_d = B_RD2;  end
        ClsLu12i:           begin a_sel_d = A_1R;    b_sel_d = B_ZERO; end
        ClsJal:             begin a_sel_d = A_SEXT1; b_sel_d = B_PC;   end
        default:            begin a_sel_d = A_RD1;   b_sel_d = B_SEXT; end
      endcase
    end
  end

  always_comb begin
    wb_sel_d = 2'd0;
    if (state_d == StWb) begin
      if (class_d == ClsLoad)     wb_sel_d = 2'd1;
      else if (class_d == ClsJal) wb_sel_d = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= state_e'(RESET_STATE);
      class_q    <= 3'd0;
      a_sel_q    <= A_RD1;
      b_sel_q    <= B_RD2;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      wb_sel_q   <= 2'd0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      dmem_req_q <= (state_d == StMem);
      dmem_we_q  <= (state_d == StMem) && (class_d == ClsStore);
      rf_we_q    <= (state_d == StWb);
      wb_sel_q   <= wb_sel_d;
      halted_q   <= (state_d == StHalt);
    end
  end

  // Only the fetch handshake, store completion and branch outcome reach outputs combinationally.
  assign imem_req = (state_q == StIf) && run;
  assign ir_we    = (state_q == StIf) && run && imem_ack;
  assign pc_we    = ((state_q == StEx) && (class_q == ClsBranch)) ||
                    ((state_q == StMem) && (class_q == ClsStore) && dmem_ack) ||
                    (state_q == StWb);
  assign pc_sel   = ((state_q == StEx) && (class_q == ClsBranch) && br_taken) ? 2'd1 :
                    ((state_q == StWb) && (class_q == ClsJal))                ? 2'd2 : 2'd0;

  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign rf_we    = rf_we_q;
  assign wb_sel   = wb_sel_q;
  assign halted   = halted_q;
  assign A_sel    = a_sel_q;
  assign B_sel    = b_sel_q;
  assign state    = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, inst_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      inst_cnt_q  <= 32'd0;
    end else begin
      if (run && !halted_q) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_we)            inst_cnt_q  <= inst_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;
`else
  assign cycle_cnt = 32'd0;
  assign inst_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction transaction model vs. cycle trace.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n, run, br_taken, imem_ack, dmem_ack;
  logic [2:0]  inst_type;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted;
  logic [1:0]  pc_sel, A_sel, B_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, inst_cnt;

  mc_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .inst_type (inst_type),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .A_sel     (A_sel),
    .B_sel     (B_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] A_RD1 = 2'd0, A_SEXT1 = 2'd1, A_1R = 2'd2;

  typedef logic [17:0] vec_t;
  vec_t       exp_q[$];
  vec_t       obs_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] prev_a, prev_b;

  // Observation vector; pc_sel/wb_sel only matter while their strobe is high.
  function automatic vec_t mk(input logic [2:0] st, input logic ireq, input logic irw,
                              input logic dreq, input logic dwe, input logic pcwe,
                              input logic [1:0] pcs, input logic rfw, input logic [1:0] wbs,
                              input logic [1:0] a, input logic [1:0] b, input logic hlt);
    return {st, ireq, irw, dreq, dwe, pcwe, pcwe ? pcs : 2'd0, rfw, rfw ? wbs : 2'd0, a, b, hlt};
  endfunction

  function automatic vec_t obs_now();
    return mk(state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
              A_sel, B_sel, halted);
  endfunction

  // Expected trace of one instruction from the class rules; hold = memory waits or halt cycles.
  task automatic build_exp(input logic [2:0] cls, input int iwait, input int hold,
                           input logic br, output int n);
    int s;
    logic [1:0] a, b;
    s = exp_q.size();
    for (int k = 0; k <= iwait; k++)
      exp_q.push_back(mk(3'd0, 1'b1, k == iwait, 0, 0, 0, 2'd0, 0, 2'd0, prev_a, prev_b, 0));
    exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, prev_a, prev_b, 0));
    if (cls == 3'd7) begin
      for (int k = 0; k < hold; k++)
        exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, prev_a, prev_b, 1));
    end else begin
      case (cls)
        3'd0, 3'd5: begin a = A_RD1;   b = 2'd0; end
        3'd2:       begin a = A_1R;    b = 2'd2; end
        3'd6:       begin a = A_SEXT1; b = 2'd3; end
        default:    begin a = A_RD1;   b = 2'd1; end
      endcase
      prev_a = a;
      prev_b = b;
      exp_q.push_back(mk(3'd2, 0, 0, 0, 0, cls == 3'd5, {1'b0, br}, 0, 2'd0, a, b, 0));
      if (cls == 3'd3 || cls == 3'd4)
        for (int j = 0; j <= hold; j++)
          exp_q.push_back(mk(3'd3, 0, 0, 1, cls == 3'd4, (cls == 3'd4) && (j == hold), 2'd0,
                             0, 2'd0, a, b, 0));
      if (cls != 3'd4 && cls != 3'd5)
        exp_q.push_back(mk(3'd4, 0, 0, 0, 0, 1, (cls == 3'd6) ? 2'd2 : 2'd0, 1,
                           (cls == 3'd3) ? 2'd1 : (cls == 3'd6) ? 2'd2 : 2'd0, a, b, 0));
    end
    n = exp_q.size() - s;
  endtask

  // Memory and decoder stimulus for n cycles of one instruction; noise on don't-care inputs.
  task automatic drive_inst(input logic [2:0] cls, input int iwait, input int hold,
                            input logic br, input logic run_mid, input int n);
    int m0;
    m0 = iwait + 3;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      run       = (run_mid && k > iwait) ? 1'b0 : 1'b1;
      imem_ack  = (k < iwait) ? 1'b0 : (k == iwait) ? 1'b1 : 1'($urandom);
      inst_type = (k == iwait + 1) ? cls : 3'($urandom);
      br_taken  = (k == iwait + 2) ? br : 1'($urandom);
      if ((cls == 3'd3 || cls == 3'd4) && k >= m0 && k <= m0 + hold) dmem_ack = (k == m0 + hold);
      else dmem_ack = 1'($urandom);
      #1 obs_q.push_back(obs_now());
    end
  endtask

  task automatic do_inst(input logic [2:0] cls, input int iwait, input int hold,
                         input logic br, input logic run_mid);
    int n;
    build_exp(cls, iwait, hold, br, n);
    drive_inst(cls, iwait, hold, br, run_mid, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; inst_type = 3'd0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    prev_a = A_RD1;
    prev_b = 2'd0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs_now() !== mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, A_RD1, 2'd0, 0)) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", obs_now(),
                         mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, A_RD1, 2'd0, 0));
    end
    checks++;
    if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", cycle_cnt, inst_cnt);
    end
    // Idle in IF with acks present but run low: nothing must move.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'($urandom);
      #1 checks++;
      if (state !== 3'd0 || imem_req !== 1'b0 || ir_we !== 1'b0) begin
        errors++; $display("FAIL idle_no_run got st=%0d req=%b irwe=%b exp 0/0/0",
                           state, imem_req, ir_we);
      end
    end
  endtask

  task automatic test_alu();
    logic [2:0] cls_tab[4] = '{3'd0, 3'd1, 3'd2, 3'd6};
    do_inst(3'd0, 0, 0, 0, 0);
    do_inst(3'd6, 0, 0, 0, 0);
    do_inst(3'd2, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      do_inst(cls_tab[$urandom_range(0, 3)], $urandom_range(0, 2), 0, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL alu cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mem();
    do_inst(3'd3, 0, 3, 0, 0);
    do_inst(3'd4, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      do_inst($urandom_range(0, 1) ? 3'd3 : 3'd4, $urandom_range(0, 2), $urandom_range(0, 4), 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mem cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_branch();
    do_inst(3'd5, 0, 0, 1, 0);
    do_inst(3'd5, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      do_inst(3'd5, $urandom_range(0, 2), 0, 1'($urandom), 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL branch cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_run_gap();
    do_inst(3'd3, 1, 2, 0, 1);
    do_inst(3'd1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, prev_a, prev_b, 0));
      @(negedge clk);
      run = 1'b0; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      #1 obs_q.push_back(obs_now());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL run_gap cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_halt();
    do_inst(3'd0, 0, 0, 0, 0);
    do_inst(3'd7, 1, 20, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    rst_n = 1'b0;
    #1 checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset got st=%0d halted=%b exp 0/0", state, halted);
    end
    do_reset();
    do_inst(3'd1, 0, 0, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL post_halt cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    build_exp(3'd3, 0, 5, 0, n);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    drive_inst(3'd3, 0, 5, 0, 0, 5);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL pre_abort cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    rst_n = 1'b0;
    #1 checks++;
    if (dmem_req !== 1'b0 || state !== 3'd0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL abort got req=%b st=%0d pcwe=%b rfwe=%b exp 0/0/0/0",
                         dmem_req, state, pc_we, rf_we);
    end
    do_reset();
  endtask

  task automatic test_perf();
    logic [31:0] exp_cyc, exp_inst;
    do_reset();
    for (int i = 0; i < 10; i++) do_inst(3'd0, 0, 0, 0, 0);
    @(negedge clk);
    run = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    exp_cyc = 32'd40; exp_inst = 32'd10;
`else
    exp_cyc = 32'd0;  exp_inst = 32'd0;
`endif
    #1 checks++;
    if (inst_cnt !== exp_inst) begin
      errors++; $display("FAIL inst_cnt got %0d exp %0d", inst_cnt, exp_inst);
    end
    checks++;
    if (cycle_cnt !== exp_cyc) begin
      errors++; $display("FAIL cycle_cnt got %0d exp %0d", cycle_cnt, exp_cyc);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL perf_trace cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_run_gap();
    test_halt();
    test_async_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the miniLA datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU operand selects (A_sel/B_sel) and the PC, IR, RF and memory enables.
- Handshakes with instruction and data memory that have variable latency.
- Instruction class arrives from the external decoder; this block holds no opcode tables.

Parameters:
- RESET_STATE, 3'd0, state entered on reset (S_IF); fixed, exposed for debug only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- run  in  1  execution enable
- inst_type  in  3  decoded class: 0 ALU_R, 1 ALU_I, 2 LU12I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP_LINK, 7 ILLEGAL
- br_taken  in  1  branch compare result from ALU, valid in EX
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (store)
- dmem_ack  in  1  data access done
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target
- A_sel  out  2  `A_RD1 / `A_SEXT1 / `A_1R codes from defines.vh
- B_sel  out  2  0 RD2, 1 SEXT, 2 ZERO, 3 PC
- rf_we  out  1  register file write
- wb_sel  out  2  0 ALU, 1 MEM, 2 PC+4
- halted  out  1  sticky illegal-instruction halt
- state  out  3  current state, debug
- cycle_cnt  out  32  perf counter (optional feature)
- inst_cnt  out  32  retired instruction count (optional feature)

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low.
- Reset:
  - state=S_IF, class register=0, halted=0.
  - All strobes and requests 0; A_sel=`A_RD1, B_sel=0, pc_sel=0, wb_sel=0.
  - Counters 0.
- Outputs are Moore decodes of the state register plus the latched class register; no input-to-output combinational path except those noted below.
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_HALT=5.
- S_IF:
  - imem_req=run.
  - On run and imem_ack in the same cycle: ir_we=1 (combinational on imem_ack), then go to S_ID.
  - imem_ack while run=0 is ignored.
- S_ID:
  - Latch inst_type into the class register.
  - Class 7 goes to S_HALT; all others go to S_EX.
  - Always one cycle.
- S_EX operand selects:
  - ALU_R: A=RD1, B=RD2. ALU_I/LOAD/STORE: A=RD1, B=SEXT.
  - LU12I: A=1R, B=ZERO. BRANCH: A=RD1, B=RD2. JUMP_LINK: A=SEXT1, B=PC.
- S_EX transitions:
  - LOAD/STORE go to S_MEM.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, then S_IF.
  - All others go to S_WB.
- A_sel/B_sel hold their S_EX value through S_MEM and S_WB so the ALU result stays stable.
- S_MEM:
  - dmem_req=1, dmem_we = (class==STORE); hold until dmem_ack.
  - On ack: LOAD goes to S_WB; STORE gives pc_we=1, pc_sel=0, then S_IF.
- S_WB:
  - rf_we=1; wb_sel: LOAD=1, JUMP_LINK=2, else 0.
  - pc_we=1; pc_sel = JUMP_LINK ? 2 : 0; then S_IF.
- S_HALT:
  - halted=1; all strobes and requests 0.
  - Exits only by reset.
- Latency with zero-wait memory: ALU/LU12I/JUMP 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each memory wait cycle adds 1.
- run deasserted mid-instruction: the instruction completes, then the FSM parks in S_IF with imem_req=0.
- dmem_ack outside S_MEM is ignored; imem_ack outside S_IF is ignored.
- pc_we and rf_we are single-cycle pulses, exactly one pc_we per retired instruction.
- Reset asserted mid-operation aborts immediately; no pulse is completed.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle with run=1 and halted=0.
  - inst_cnt increments on each pc_we pulse.
  - Both wrap modulo 2^32.
- Undefined: both ports are driven constant 0 and no counter flops are inferred; ports remain present.

Test Plan:
- ALU_R, zero-wait imem: run=1, imem_ack=1, type=0 -> states 0,1,2,4,0; A_sel=`A_RD1, B_sel=0 in EX/WB; single rf_we and pc_we in cycle 4; pc_sel=0.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; wb_sel=1 and rf_we in WB; total 8 cycles.
- BRANCH br_taken=1 then br_taken=0 -> pc_we in EX with pc_sel=1, then pc_sel=0; rf_we never asserted; 3 cycles each.
- JUMP_LINK and LU12I -> A_sel=`A_SEXT1/B_sel=3, wb_sel=2, pc_sel=2; LU12I A_sel=`A_1R, B_sel=2.
- type=7 -> S_HALT after ID, halted=1, imem_req stays 0 for 20 cycles; rst_n pulse clears to S_IF.
- rst_n low during S_MEM with dmem_req=1 -> dmem_req=0 asynchronously, state=0; with CTRL_PERF_CNT_EN, 10 ALU instructions give inst_cnt=10, cycle_cnt=40.
